// File: rtl/axi_ram_slave.sv
// axi_ram_slave
//   Data RAM behind split AXI-lite-style read and write channels (valid/ready
//   handshakes, byte strobes, B response), plus a registered 32-bit
//   instruction-fetch port.
//
//   Build option: define AXI_RAM_UNALIGNED_EN to serve accesses that span two
//   words as two beats (LO then HI). Without it, any access with a nonzero
//   byte offset is refused with SLVERR and leaves memory untouched.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   ar_valid_i/ar_ready_o    read request handshake, ar_addr_i byte address
//   r_valid_o/r_ready_i      read data handshake, r_data_o / r_resp_o
//   aw_valid_i/aw_ready_o    write request handshake (address, data, strobe together)
//   aw_addr_i, w_data_i, w_strb_i
//   b_valid_o/b_ready_i      write response handshake, b_resp_o
//   inst_addr_i, inst_o      fetch address in, instruction out one cycle later
module axi_ram_slave #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 4096,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ar_valid_i,
   output logic              ar_ready_o,
   input  logic [ADDR_W-1:0] ar_addr_i,
   output logic              r_valid_o,
   input  logic              r_ready_i,
   output logic [DATA_W-1:0] r_data_o,
   output logic [1:0]        r_resp_o,
   input  logic              aw_valid_i,
   output logic              aw_ready_o,
   input  logic [ADDR_W-1:0] aw_addr_i,
   input  logic [DATA_W-1:0] w_data_i,
   input  logic [DATA_W/8-1:0] w_strb_i,
   output logic              b_valid_o,
   input  logic              b_ready_i,
   output logic [1:0]        b_resp_o,
   input  logic [ADDR_W-1:0] inst_addr_i,
   output logic [31:0]       inst_o
);
   // state   | meaning
   // *_IDLE  | ready for a request
   // *_LO    | first (or only) word beat
   // *_HI    | second word beat of a misaligned access (unaligned build only)
   // *_RESP  | response held until the master accepts it

   localparam int BYTES  = DATA_W / 8;
   localparam int OFF_W  = $clog2(BYTES);
   localparam int IDX_W  = $clog2(DEPTH);
   localparam int LANE_W = (OFF_W > 2) ? OFF_W - 2 : 1;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_LO   = 2'd1,
      RD_RESP = 2'd2
`ifdef AXI_RAM_UNALIGNED_EN
      , RD_HI = 2'd3
`endif
   } rd_state_t;

   typedef enum logic [1:0] {
      WR_IDLE = 2'd0,
      WR_LO   = 2'd1,
      WR_RESP = 2'd2
`ifdef AXI_RAM_UNALIGNED_EN
      , WR_HI = 2'd3
`endif
   } wr_state_t;

   logic [DATA_W-1:0] mem [DEPTH];

   rd_state_t rd_state, rd_next;
   wr_state_t wr_state, wr_next;

   logic [IDX_W-1:0]  rd_idx;
   logic [OFF_W-1:0]  rd_off;
   logic [DATA_W-1:0] rd_data;
   logic [1:0]        rd_resp;

   logic [IDX_W-1:0]  wr_idx;
   logic [OFF_W-1:0]  wr_off;
   logic [DATA_W-1:0] wr_data;
   logic [BYTES-1:0]  wr_strb;
   logic [1:0]        wr_resp;

   logic [BYTES-1:0]  lo_strb;
   logic [DATA_W-1:0] lo_data;

   assign ar_ready_o = (rd_state == RD_IDLE) & rst;
   assign aw_ready_o = (wr_state == WR_IDLE) & rst;
   assign r_valid_o  = (rd_state == RD_RESP);
   assign b_valid_o  = (wr_state == WR_RESP);
   assign r_data_o   = rd_data;
   assign r_resp_o   = rd_resp;
   assign b_resp_o   = wr_resp;

`ifdef AXI_RAM_UNALIGNED_EN
   logic [IDX_W-1:0]    rd_idx_nx;
   logic [IDX_W-1:0]    wr_idx_nx;
   logic [DATA_W-1:0]   rd_lo;
   logic [2*DATA_W-1:0] rd_pair;
   logic [2*BYTES-1:0]  wr_strb_wide;
   logic [2*DATA_W-1:0] wr_data_wide;
   logic [BYTES-1:0]    hi_strb;
   logic [DATA_W-1:0]   hi_data;

   // Word index arithmetic wraps DEPTH-1 -> 0 through the IDX_W width.
   assign rd_idx_nx    = rd_idx + IDX_W'(1);
   assign wr_idx_nx    = wr_idx + IDX_W'(1);
   assign rd_pair      = {mem[rd_idx_nx], rd_lo} >> {rd_off, 3'b000};
   // Shifting into a double-width vector splits strobe/data across both words.
   assign wr_strb_wide = {{BYTES{1'b0}}, wr_strb} << wr_off;
   assign wr_data_wide = {{DATA_W{1'b0}}, wr_data} << {wr_off, 3'b000};
   assign lo_strb      = wr_strb_wide[BYTES-1:0];
   assign lo_data      = wr_data_wide[DATA_W-1:0];
   assign hi_strb      = wr_strb_wide[2*BYTES-1:BYTES];
   assign hi_data      = wr_data_wide[2*DATA_W-1:DATA_W];
`else
   // Misaligned requests are refused, so they must not touch memory.
   assign lo_strb = (wr_off == '0) ? wr_strb : '0;
   assign lo_data = wr_data;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_state <= RD_IDLE;
         wr_state <= WR_IDLE;
      end else begin
         rd_state <= rd_next;
         wr_state <= wr_next;
      end
   end

   always_comb begin
      rd_next = rd_state;
      case (rd_state)
         RD_IDLE: if (ar_valid_i) rd_next = RD_LO;
`ifdef AXI_RAM_UNALIGNED_EN
         RD_LO:   rd_next = (rd_off == '0) ? RD_RESP : RD_HI;
         RD_HI:   rd_next = RD_RESP;
`else
         RD_LO:   rd_next = RD_RESP;
`endif
         RD_RESP: if (r_ready_i) rd_next = RD_IDLE;
         default: rd_next = RD_IDLE;
      endcase
   end

   always_comb begin
      wr_next = wr_state;
      case (wr_state)
         WR_IDLE: if (aw_valid_i) wr_next = WR_LO;
`ifdef AXI_RAM_UNALIGNED_EN
         WR_LO:   wr_next = (wr_off == '0) ? WR_RESP : WR_HI;
         WR_HI:   wr_next = WR_RESP;
`else
         WR_LO:   wr_next = WR_RESP;
`endif
         WR_RESP: if (b_ready_i) wr_next = WR_IDLE;
         default: wr_next = WR_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_idx  <= '0;
         rd_off  <= '0;
         rd_data <= '0;
         rd_resp <= OKAY;
`ifdef AXI_RAM_UNALIGNED_EN
         rd_lo   <= '0;
`endif
      end else begin
         case (rd_state)
            RD_IDLE: begin
               if (ar_valid_i) begin
                  rd_idx <= ar_addr_i[OFF_W+IDX_W-1:OFF_W];
                  rd_off <= ar_addr_i[OFF_W-1:0];
               end
            end
            RD_LO: begin
               if (rd_off == '0) begin
                  rd_data <= mem[rd_idx];
                  rd_resp <= OKAY;
               end else begin
`ifdef AXI_RAM_UNALIGNED_EN
                  rd_lo   <= mem[rd_idx];
`else
                  rd_data <= '0;
                  rd_resp <= SLVERR;
`endif
               end
            end
`ifdef AXI_RAM_UNALIGNED_EN
            RD_HI: begin
               rd_data <= rd_pair[DATA_W-1:0];
               rd_resp <= OKAY;
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_idx  <= '0;
         wr_off  <= '0;
         wr_data <= '0;
         wr_strb <= '0;
         wr_resp <= OKAY;
      end else if (wr_state == WR_IDLE && aw_valid_i) begin
         wr_idx  <= aw_addr_i[OFF_W+IDX_W-1:OFF_W];
         wr_off  <= aw_addr_i[OFF_W-1:0];
         wr_data <= w_data_i;
         wr_strb <= w_strb_i;
`ifdef AXI_RAM_UNALIGNED_EN
         wr_resp <= OKAY;
`else
         wr_resp <= (aw_addr_i[OFF_W-1:0] == '0) ? OKAY : SLVERR;
`endif
      end
   end

   // Byte-enabled memory update; the read path samples mem with the same
   // edge, so a same-cycle read of the word sees the old contents.
   always_ff @(posedge clk) begin
      for (int b = 0; b < BYTES; b++) begin
         if (wr_state == WR_LO && lo_strb[b])
            mem[wr_idx][8*b +: 8] <= lo_data[8*b +: 8];
`ifdef AXI_RAM_UNALIGNED_EN
         if (wr_state == WR_HI && hi_strb[b])
            mem[wr_idx_nx][8*b +: 8] <= hi_data[8*b +: 8];
`endif
      end
   end

   logic [IDX_W-1:0]  f_idx;
   logic [LANE_W-1:0] f_lane;

   assign f_idx  = inst_addr_i[OFF_W+IDX_W-1:OFF_W];
   assign f_lane = LANE_W'(inst_addr_i[OFF_W-1:0] >> 2);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) inst_o <= '0;
      else      inst_o <= mem[f_idx][{f_lane, 5'b00000} +: 32];
   end

   // Address bits above the index alias; fetch addresses are word aligned.
   logic unused_addr;
   assign unused_addr = ^{ar_addr_i[ADDR_W-1:OFF_W+IDX_W], aw_addr_i[ADDR_W-1:OFF_W+IDX_W],
                          inst_addr_i[ADDR_W-1:OFF_W+IDX_W], inst_addr_i[1:0]};

endmodule
